// File: rtl/noc_pkg.sv
// Shared NoC definitions: direction codes, packet field positions,
// handshake FSM state encodings and the XY routing function.
package noc_pkg;

    localparam int WIDTH_PACKET_DEF = 57;
    localparam int NUM_DIRS         = 5;

    localparam int DEST_X_HI  = 56;
    localparam int DEST_X_LO  = 55;
    localparam int DEST_Y_HI  = 54;
    localparam int DEST_Y_LO  = 53;
    localparam int SRC_HI     = 52;
    localparam int SRC_LO     = 49;
    localparam int PAYLOAD_HI = 48;

    typedef enum logic [2:0] {
        DIR_N     = 3'd0,
        DIR_E     = 3'd1,
        DIR_S     = 3'd2,
        DIR_W     = 3'd3,
        DIR_LOCAL = 3'd4
    } dir_e;

    typedef enum logic {
        IN_IDLE = 1'b0,
        IN_ACK  = 1'b1
    } in_state_e;

    typedef enum logic [1:0] {
        OUT_IDLE = 2'd0,
        OUT_REQ  = 2'd1,
        OUT_REL  = 2'd2
    } out_state_e;

    typedef struct packed {
        logic [DEST_X_HI-DEST_X_LO:0] dest_x;
        logic [DEST_Y_HI-DEST_Y_LO:0] dest_y;
        logic [SRC_HI-SRC_LO:0]       src;
        logic [PAYLOAD_HI:0]          payload;
    } pkt_t;

    // Dimension-ordered routing: resolve X completely before looking at Y.
    function automatic dir_e xy_route(input logic [1:0] dest_x, input logic [1:0] dest_y,
                                      input logic [1:0] here_x, input logic [1:0] here_y);
        if (dest_x > here_x)      return DIR_E;
        else if (dest_x < here_x) return DIR_W;
        else if (dest_y > here_y) return DIR_N;
        else if (dest_y < here_y) return DIR_S;
        else                      return DIR_LOCAL;
    endfunction

endpackage

// File: rtl/route_fifo.sv
// Circular packet buffer of DEPTH entries (power of two); the head entry is
// presented combinationally so the routing logic can inspect it before popping.
module route_fifo #(
    parameter int WIDTH = 57,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic             o_full,
    output logic             o_empty,
    output logic [WIDTH-1:0] o_head
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign w_push_ok = i_push && !o_full;
    assign w_pop_ok  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/input_ctrl_route.sv
// Router input port: 4-phase upstream handshake into a small buffer, XY route of
// the head packet, 4-phase request/ack toward the chosen output controller.
// Optional macro ROUTE_ERR_CNT_EN adds a saturating count of dropped U-turn packets.
module input_ctrl_route
    import noc_pkg::*;
#(
    parameter int WIDTH_packet = WIDTH_PACKET_DEF,
    parameter int DEPTH        = 2,
    parameter int ROUTER_X     = 0,
    parameter int ROUTER_Y     = 0,
    parameter int IN_DIR       = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_req,
    output logic                    in_ack,
    input  logic [WIDTH_packet-1:0] in_data,
    output logic [NUM_DIRS-1:0]     out_req,
    input  logic [NUM_DIRS-1:0]     out_ack,
    output logic [WIDTH_packet-1:0] out_data
`ifdef ROUTE_ERR_CNT_EN
    ,
    output logic [7:0]              route_err_cnt
`endif
);

    localparam logic [1:0] HERE_X   = ROUTER_X[1:0];
    localparam logic [1:0] HERE_Y   = ROUTER_Y[1:0];
    localparam logic [2:0] IN_DIR_C = IN_DIR[2:0];

    in_state_e               r_in_state, w_in_next;
    out_state_e              r_out_state, w_out_next;
    dir_e                    r_dir, w_dir_next;
    dir_e                    w_route;
    logic                    r_wait_low;
    logic                    w_push;
    logic                    w_pop;
    logic                    w_full;
    logic                    w_empty;
    logic [WIDTH_packet-1:0] w_head;
    logic [NUM_DIRS-1:0]     w_out_req;

    route_fifo #(
        .WIDTH (WIDTH_packet),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  (in_data),
        .i_pop   (w_pop),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head)
    );

    assign w_route = xy_route(w_head[DEST_X_HI:DEST_X_LO], w_head[DEST_Y_HI:DEST_Y_LO],
                              HERE_X, HERE_Y);

    // r_wait_low blocks a request left high across reset from being taken as new.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_state  <= IN_IDLE;
            r_wait_low  <= 1'b1;
            r_out_state <= OUT_IDLE;
            r_dir       <= DIR_LOCAL;
        end else begin
            r_in_state  <= w_in_next;
            r_out_state <= w_out_next;
            r_dir       <= w_dir_next;
            if (!in_req) r_wait_low <= 1'b0;
        end
    end

    always_comb begin
        w_in_next = r_in_state;
        w_push    = 1'b0;
        case (r_in_state)
            IN_IDLE: begin
                if (in_req && !w_full && !r_wait_low) begin
                    w_push    = 1'b1;
                    w_in_next = IN_ACK;
                end
            end
            IN_ACK: begin
                if (!in_req) w_in_next = IN_IDLE;
            end
            default: w_in_next = IN_IDLE;
        endcase
    end

    // A head routed back out of its own input port is discarded straight from idle.
    always_comb begin
        w_out_next = r_out_state;
        w_dir_next = r_dir;
        w_pop      = 1'b0;
        case (r_out_state)
            OUT_IDLE: begin
                if (!w_empty) begin
                    if (w_route == IN_DIR_C) begin
                        w_pop = 1'b1;
                    end else begin
                        w_out_next = OUT_REQ;
                        w_dir_next = w_route;
                    end
                end
            end
            OUT_REQ: begin
                if (out_ack[r_dir]) w_out_next = OUT_REL;
            end
            OUT_REL: begin
                if (!out_ack[r_dir]) begin
                    w_pop      = 1'b1;
                    w_out_next = OUT_IDLE;
                end
            end
            default: w_out_next = OUT_IDLE;
        endcase
    end

    always_comb begin
        w_out_req = '0;
        for (int d = 0; d < NUM_DIRS; d++) begin
            w_out_req[d] = (r_out_state == OUT_REQ) && (r_dir == dir_e'(d)) && (d != IN_DIR);
        end
    end

    assign in_ack   = (r_in_state == IN_ACK);
    assign out_req  = w_out_req;
    assign out_data = w_empty ? '0 : w_head;

`ifdef ROUTE_ERR_CNT_EN
    logic       w_uturn;
    logic [7:0] r_err_cnt;

    assign w_uturn = (r_out_state == OUT_IDLE) && !w_empty && (w_route == IN_DIR_C);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_err_cnt <= '0;
        end else if (w_uturn && (r_err_cnt != 8'hFF)) begin
            r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign route_err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_input_ctrl_route.sv
// Directed bench for input_ctrl_route: two instances at router (1,1), one serving
// LOCAL and one serving E, driven through table vectors plus multi-cycle sequences.
module tb_input_ctrl_route;

    logic        clk = 1'b0;
    logic        rst;
    logic        inReq   [2];
    logic        inAck   [2];
    logic [56:0] inData  [2];
    logic [4:0]  outReq  [2];
    logic [4:0]  outAck  [2];
    logic [56:0] outData [2];
`ifdef ROUTE_ERR_CNT_EN
    logic [7:0]  errCnt  [2];
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    input_ctrl_route #(.ROUTER_X(1), .ROUTER_Y(1), .IN_DIR(4)) dutLocal (
        .clk      (clk),
        .rst      (rst),
        .in_req   (inReq[0]),
        .in_ack   (inAck[0]),
        .in_data  (inData[0]),
        .out_req  (outReq[0]),
        .out_ack  (outAck[0]),
        .out_data (outData[0])
`ifdef ROUTE_ERR_CNT_EN
        ,
        .route_err_cnt (errCnt[0])
`endif
    );

    input_ctrl_route #(.ROUTER_X(1), .ROUTER_Y(1), .IN_DIR(1)) dutEast (
        .clk      (clk),
        .rst      (rst),
        .in_req   (inReq[1]),
        .in_ack   (inAck[1]),
        .in_data  (inData[1]),
        .out_req  (outReq[1]),
        .out_ack  (outAck[1]),
        .out_data (outData[1])
`ifdef ROUTE_ERR_CNT_EN
        ,
        .route_err_cnt (errCnt[1])
`endif
    );

    typedef struct {
        int         sel;
        logic [1:0] dx;
        logic [1:0] dy;
        logic [4:0] expReq;
        string      name;
    } vec_t;

    vec_t vecs [9];

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic applyStimulus(input int sel, input logic req, input logic [56:0] data,
                                 input logic [4:0] ack);
        inReq[sel]  = req;
        inData[sel] = data;
        outAck[sel] = ack;
    endtask

    task automatic checkOutput(input string name, input logic [63:0] actual,
                               input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    function automatic logic [56:0] makePkt(input logic [1:0] dx, input logic [1:0] dy);
        logic [63:0] rnd;
        rnd = {$urandom(), $urandom()};
        return {dx, dy, 4'h5, rnd[48:0]};
    endfunction

    // One full packet: write, request, ack, release, pop.
    task automatic doTransaction(input int sel, input logic [1:0] dx, input logic [1:0] dy,
                                 input logic [4:0] expReq, input string name);
        logic [56:0] pkt;
        pkt = makePkt(dx, dy);
        applyStimulus(sel, 1'b1, pkt, 5'b0);
        tick();
        checkOutput({name, "_inack"}, 64'(inAck[sel]), 64'(1));
        checkOutput({name, "_noreq"}, 64'(outReq[sel]), 64'(0));
        applyStimulus(sel, 1'b0, pkt, 5'b0);
        tick();
        checkOutput({name, "_req"}, 64'(outReq[sel]), 64'(expReq));
        checkOutput({name, "_data"}, 64'(outData[sel]), 64'(pkt));
        checkOutput({name, "_inackdrop"}, 64'(inAck[sel]), 64'(0));
        applyStimulus(sel, 1'b0, pkt, expReq);
        tick();
        checkOutput({name, "_reqdrop"}, 64'(outReq[sel]), 64'(0));
        checkOutput({name, "_datahold"}, 64'(outData[sel]), 64'(pkt));
        applyStimulus(sel, 1'b0, pkt, 5'b0);
        tick();
        checkOutput({name, "_popped"}, 64'(outData[sel]), 64'(0));
    endtask

    // U-turn: the head is dropped one edge after it is written, with no request.
    task automatic doUturn(input string name);
        logic [56:0] pkt;
        pkt = makePkt(2'd3, 2'd0);
        applyStimulus(1, 1'b1, pkt, 5'b0);
        tick();
        checkOutput({name, "_noreq0"}, 64'(outReq[1]), 64'(0));
        checkOutput({name, "_head"}, 64'(outData[1]), 64'(pkt));
        applyStimulus(1, 1'b0, pkt, 5'b0);
        tick();
        checkOutput({name, "_noreq1"}, 64'(outReq[1]), 64'(0));
        checkOutput({name, "_dropped"}, 64'(outData[1]), 64'(0));
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [56:0] pA, pB, pC, pQ;

        vecs[0] = '{0, 2'd2, 2'd1, 5'b00010, "east"};
        vecs[1] = '{0, 2'd0, 2'd1, 5'b01000, "west"};
        vecs[2] = '{0, 2'd1, 2'd2, 5'b00001, "north"};
        vecs[3] = '{0, 2'd1, 2'd0, 5'b00100, "south"};
        vecs[4] = '{0, 2'd3, 2'd3, 5'b00010, "east_xfirst"};
        vecs[5] = '{0, 2'd1, 2'd3, 5'b00001, "north_far"};
        vecs[6] = '{0, 2'd0, 2'd0, 5'b01000, "west_corner"};
        vecs[7] = '{1, 2'd1, 2'd1, 5'b10000, "local"};
        vecs[8] = '{1, 2'd0, 2'd2, 5'b01000, "west_b"};

        rst = 1'b1;
        applyStimulus(0, 1'b0, '0, 5'b0);
        applyStimulus(1, 1'b0, '0, 5'b0);
        tick();
        tick();
        for (int s = 0; s < 2; s++) begin
            checkOutput($sformatf("rst_inack%0d", s), 64'(inAck[s]), 64'(0));
            checkOutput($sformatf("rst_outreq%0d", s), 64'(outReq[s]), 64'(0));
            checkOutput($sformatf("rst_outdata%0d", s), 64'(outData[s]), 64'(0));
`ifdef ROUTE_ERR_CNT_EN
            checkOutput($sformatf("rst_errcnt%0d", s), 64'(errCnt[s]), 64'(0));
`endif
        end
        rst = 1'b0;
        tick();

        for (int i = 0; i < 9; i++) begin
            doTransaction(vecs[i].sel, vecs[i].dx, vecs[i].dy, vecs[i].expReq, vecs[i].name);
        end

        // Acks on directions other than the active one must not advance the handshake.
        pA = makePkt(2'd2, 2'd1);
        applyStimulus(0, 1'b1, pA, 5'b0);
        tick();
        applyStimulus(0, 1'b0, pA, 5'b0);
        tick();
        applyStimulus(0, 1'b0, pA, 5'b11101);
        tick();
        checkOutput("stray_ack_req", 64'(outReq[0]), 64'(5'b00010));
        applyStimulus(0, 1'b0, pA, 5'b00010);
        tick();
        checkOutput("stray_ack_rel", 64'(outReq[0]), 64'(0));
        applyStimulus(0, 1'b0, pA, 5'b0);
        tick();
        checkOutput("stray_ack_pop", 64'(outData[0]), 64'(0));

        // LOCAL destination on the LOCAL-serving instance is a U-turn.
        pA = makePkt(2'd1, 2'd1);
        applyStimulus(0, 1'b1, pA, 5'b0);
        tick();
        checkOutput("local_uturn_noreq", 64'(outReq[0]), 64'(0));
        applyStimulus(0, 1'b0, pA, 5'b0);
        tick();
        checkOutput("local_uturn_drop", 64'(outData[0]), 64'(0));
        checkOutput("local_uturn_noreq1", 64'(outReq[0]), 64'(0));
`ifdef ROUTE_ERR_CNT_EN
        checkOutput("local_uturn_cnt", 64'(errCnt[0]), 64'(1));
`endif

        // Three back-to-back packets against a stalled output.
        pA = makePkt(2'd2, 2'd1);
        pB = makePkt(2'd2, 2'd2);
        pC = makePkt(2'd3, 2'd0);
        applyStimulus(0, 1'b1, pA, 5'b0);
        tick();
        checkOutput("b2b_ackA", 64'(inAck[0]), 64'(1));
        applyStimulus(0, 1'b0, pA, 5'b0);
        tick();
        checkOutput("b2b_reqA", 64'(outReq[0]), 64'(5'b00010));
        applyStimulus(0, 1'b1, pB, 5'b0);
        tick();
        checkOutput("b2b_ackB", 64'(inAck[0]), 64'(1));
        applyStimulus(0, 1'b0, pB, 5'b0);
        tick();
        applyStimulus(0, 1'b1, pC, 5'b0);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput($sformatf("b2b_full%0d", i), 64'(inAck[0]), 64'(0));
        end
        checkOutput("b2b_dataA", 64'(outData[0]), 64'(pA));
        applyStimulus(0, 1'b1, pC, 5'b00010);
        tick();
        checkOutput("b2b_rel_full", 64'(inAck[0]), 64'(0));
        applyStimulus(0, 1'b1, pC, 5'b0);
        tick();
        checkOutput("b2b_pop_same_edge", 64'(inAck[0]), 64'(0));
        checkOutput("b2b_headB", 64'(outData[0]), 64'(pB));
        tick();
        checkOutput("b2b_ackC", 64'(inAck[0]), 64'(1));
        checkOutput("b2b_reqB", 64'(outReq[0]), 64'(5'b00010));
        applyStimulus(0, 1'b0, pC, 5'b00010);
        tick();
        checkOutput("b2b_relB", 64'(outReq[0]), 64'(0));
        applyStimulus(0, 1'b0, pC, 5'b0);
        tick();
        checkOutput("b2b_headC", 64'(outData[0]), 64'(pC));
        tick();
        checkOutput("b2b_reqC", 64'(outReq[0]), 64'(5'b00010));
        applyStimulus(0, 1'b0, pC, 5'b00010);
        tick();
        applyStimulus(0, 1'b0, pC, 5'b0);
        tick();
        checkOutput("b2b_empty", 64'(outData[0]), 64'(0));

        // U-turns on the east-serving instance, then saturation of the counter.
        doUturn("uturn1");
`ifdef ROUTE_ERR_CNT_EN
        checkOutput("uturn_cnt1", 64'(errCnt[1]), 64'(1));
`endif
        for (int i = 0; i < 255; i++) begin
            applyStimulus(1, 1'b1, makePkt(2'd2, 2'd3), 5'b0);
            tick();
            applyStimulus(1, 1'b0, '0, 5'b0);
            tick();
        end
        checkOutput("uturn_many_empty", 64'(outData[1]), 64'(0));
`ifdef ROUTE_ERR_CNT_EN
        checkOutput("uturn_cnt_sat", 64'(errCnt[1]), 64'(255));
`endif
        doUturn("uturn_after_sat");
`ifdef ROUTE_ERR_CNT_EN
        checkOutput("uturn_cnt_hold", 64'(errCnt[1]), 64'(255));
`endif

        // Reset while a request is outstanding, with the upstream request held high.
        pA = makePkt(2'd2, 2'd1);
        pQ = makePkt(2'd0, 2'd1);
        applyStimulus(0, 1'b1, pA, 5'b0);
        tick();
        applyStimulus(0, 1'b0, pA, 5'b0);
        tick();
        checkOutput("rstmid_pre_req", 64'(outReq[0]), 64'(5'b00010));
        applyStimulus(0, 1'b1, pQ, 5'b0);
        rst = 1'b1;
        tick();
        checkOutput("rstmid_outreq", 64'(outReq[0]), 64'(0));
        checkOutput("rstmid_inack", 64'(inAck[0]), 64'(0));
        checkOutput("rstmid_empty", 64'(outData[0]), 64'(0));
`ifdef ROUTE_ERR_CNT_EN
        checkOutput("rstmid_errcnt", 64'(errCnt[1]), 64'(0));
`endif
        rst = 1'b0;
        tick();
        tick();
        checkOutput("rstmid_wait_low_ack", 64'(inAck[0]), 64'(0));
        checkOutput("rstmid_wait_low_data", 64'(outData[0]), 64'(0));
        applyStimulus(0, 1'b0, pQ, 5'b0);
        tick();
        doTransaction(0, 2'd1, 2'd0, 5'b00100, "post_rst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
